// File: rtl/branch_decoder_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_decoder_unit_pkg : next-PC select encoding shared with the hazard unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package branch_decoder_unit_pkg;

  typedef enum logic [1:0] {
    PcPlus4  = 2'd0,
    PcBranch = 2'd1,
    PcJal    = 2'd2,
    PcJalr   = 2'd3
  } pc_src_t;

endpackage

`default_nettype wire

// File: rtl/hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_unit_pkg : hazard class encodings and register-match helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hazard_unit_pkg;

  typedef enum logic [1:0] {
    NoHazard        = 2'd0,
    HazardDecode    = 2'd1,
    HazardExecute   = 2'd2,
    HazardException = 2'd3
  } hazard_t;

  typedef enum logic {
    Rs1Only = 1'b0,
    Rs1Rs2  = 1'b1
  } rs_used_t;

  // x0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic match(input logic [4:0] rs, input logic [4:0] rd,
                                 input logic we, input logic en);
    return (rs == rd) && (rd != 5'd0) && we && en;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_unit_if : pipeline state in, stall/flush controls out
// Optional counters exist when HAZARD_STATS_EN is defined.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pipeline_hazard_unit_if
  import hazard_unit_pkg::*, branch_decoder_unit_pkg::*;
  ();

  hazard_t     hazard_type;
  rs_used_t    rs_used;
  pc_src_t     pc_src;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic [4:0]  rd_ex;
  logic [4:0]  rd_mem;
  logic        reg_we_ex;
  logic        reg_we_mem;
  logic        mem_rd_en_ex;
  logic        mem_rd_en_mem;
  logic        store_id;
  logic        rd_complete_ex;
  logic        stall_if;
  logic        stall_id;
  logic        flush_id;
  logic        flush_ex;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count;
  logic [31:0] flush_count;
`endif

  modport master (
    output hazard_type, rs_used, pc_src, rs1_id, rs2_id, rd_ex, rd_mem,
           reg_we_ex, reg_we_mem, mem_rd_en_ex, mem_rd_en_mem, store_id,
           rd_complete_ex,
`ifdef HAZARD_STATS_EN
    input  stall_count, flush_count,
`endif
    input  stall_if, stall_id, flush_id, flush_ex
  );

  modport slave (
    input  hazard_type, rs_used, pc_src, rs1_id, rs2_id, rd_ex, rd_mem,
           reg_we_ex, reg_we_mem, mem_rd_en_ex, mem_rd_en_mem, store_id,
           rd_complete_ex,
`ifdef HAZARD_STATS_EN
    output stall_count, flush_count,
`endif
    output stall_if, stall_id, flush_id, flush_ex
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_unit_perf_counter.sv
// ---------------------------------------------------------------------------
// hazard_perf_counter : 32-bit enabled event counter, sync reset, wraps.
// Exists only when HAZARD_STATS_EN is defined.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifdef HAZARD_STATS_EN
module hazard_perf_counter (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_en,
  output logic [31:0]      o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 32'd0;
    end else if (i_en) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule
`endif

`default_nettype wire

// File: rtl/pipeline_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_unit : combinational RAW/load-use hazard detection with
// stall/flush generation; HAZARD_STATS_EN adds stall/flush counters.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_unit
  import hazard_unit_pkg::*, branch_decoder_unit_pkg::*;
(
  input  wire logic               clock,
  input  wire logic               reset,
  pipeline_hazard_unit_if.slave   hz
);

  logic [4:0] w_rs2_eff;
  logic       w_hit_rs1;
  logic       w_hit_rs2;
  logic       w_hit;
  logic       w_exception;
  logic       w_redirect;

  // An unused rs2 is steered to x0, which can never match a destination.
  assign w_rs2_eff = (hz.rs_used == Rs1Rs2) ? hz.rs2_id : 5'd0;

  always_comb begin
    w_hit_rs1 = 1'b0;
    w_hit_rs2 = 1'b0;
    case (hz.hazard_type)
      HazardDecode: begin
        w_hit_rs1 = match(hz.rs1_id, hz.rd_ex, hz.reg_we_ex, !hz.rd_complete_ex) ||
                    match(hz.rs1_id, hz.rd_mem, hz.reg_we_mem, hz.mem_rd_en_mem);
        w_hit_rs2 = match(w_rs2_eff, hz.rd_ex, hz.reg_we_ex, !hz.rd_complete_ex) ||
                    match(w_rs2_eff, hz.rd_mem, hz.reg_we_mem, hz.mem_rd_en_mem);
      end
      HazardExecute: begin
        // Store data on rs2 is forwarded later, so it never causes a load-use stall.
        w_hit_rs1 = match(hz.rs1_id, hz.rd_ex, hz.reg_we_ex, hz.mem_rd_en_ex);
        w_hit_rs2 = match(w_rs2_eff, hz.rd_ex, hz.reg_we_ex,
                          hz.mem_rd_en_ex && !hz.store_id);
      end
      default: begin
        w_hit_rs1 = 1'b0;
        w_hit_rs2 = 1'b0;
      end
    endcase
  end

  assign w_hit       = w_hit_rs1 || w_hit_rs2;
  assign w_exception = (hz.hazard_type == HazardException);
  assign w_redirect  = (hz.pc_src != PcPlus4);

  assign hz.stall_if = w_hit;
  assign hz.stall_id = w_hit;
  assign hz.flush_ex = w_hit || w_exception;
  assign hz.flush_id = w_exception || w_redirect;

`ifdef HAZARD_STATS_EN
  hazard_perf_counter u_stall_cnt (
    .clk     (clock),
    .rst     (reset),
    .i_en    (hz.stall_id),
    .o_count (hz.stall_count)
  );

  hazard_perf_counter u_flush_cnt (
    .clk     (clock),
    .rst     (reset),
    .i_en    (hz.flush_ex),
    .o_count (hz.flush_count)
  );
`else
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clock | reset;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_unit : scoreboard bench for pipeline_hazard_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_hazard_unit;
  import hazard_unit_pkg::*;
  import branch_decoder_unit_pkg::*;

  logic clock;
  logic reset;
  logic vec_vld;
  int   checks;
  int   errors;
  logic [3:0] exp_q[$];

  pipeline_hazard_unit_if hif ();

  pipeline_hazard_unit dut (
    .clock (clock),
    .reset (reset),
    .hz    (hif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected/actual packing: {stall_if, stall_id, flush_id, flush_ex}
  task automatic apply(input hazard_t ht, input logic ru, input pc_src_t pc,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rde, input logic [4:0] rdm,
                       input logic wee, input logic wem, input logic mre,
                       input logic mrm, input logic st, input logic cmp,
                       input logic [3:0] exp);
    @(posedge clock);
    #1;
    hif.hazard_type    = ht;
    hif.rs_used        = rs_used_t'(ru);
    hif.pc_src         = pc;
    hif.rs1_id         = rs1;
    hif.rs2_id         = rs2;
    hif.rd_ex          = rde;
    hif.rd_mem         = rdm;
    hif.reg_we_ex      = wee;
    hif.reg_we_mem     = wem;
    hif.mem_rd_en_ex   = mre;
    hif.mem_rd_en_mem  = mrm;
    hif.store_id       = st;
    hif.rd_complete_ex = cmp;
    exp_q.push_back(exp);
    vec_vld = 1'b1;
  endtask

  function automatic logic m(input logic [4:0] rs, input logic [4:0] rd,
                             input logic we, input logic en);
    return (rs == rd) && (rd != 5'd0) && we && en;
  endfunction

  // Reference: hit per source, then OR.
  function automatic logic [3:0] model(input hazard_t ht, input logic ru, input pc_src_t pc,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] rde, input logic [4:0] rdm,
                                       input logic wee, input logic wem, input logic mre,
                                       input logic mrm, input logic st, input logic cmp);
    logic [4:0] r2;
    logic h1, h2, hit, exc;
    r2 = ru ? rs2 : 5'd0;
    h1 = 1'b0;
    h2 = 1'b0;
    if (ht == HazardDecode) begin
      h1 = m(rs1, rde, wee, !cmp) | m(rs1, rdm, wem, mrm);
      h2 = m(r2,  rde, wee, !cmp) | m(r2,  rdm, wem, mrm);
    end else if (ht == HazardExecute) begin
      h1 = m(rs1, rde, wee, mre);
      h2 = m(r2,  rde, wee, mre & ~st);
    end
    hit = h1 | h2;
    exc = (ht == HazardException);
    return {hit, hit, exc | (pc != PcPlus4), hit | exc};
  endfunction

  always @(negedge clock) begin
    if (vec_vld) begin
      logic [3:0] act;
      logic [3:0] exp;
      act = {hif.stall_if, hif.stall_id, hif.flush_id, hif.flush_ex};
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL scoreboard_underflow actual=%b required=<queued entry>", act);
      end else begin
        exp = exp_q.pop_front();
        checks = checks + 1;
        if (act !== exp) begin
          errors = errors + 1;
          $display("FAIL vec%0d {stall_if,stall_id,flush_id,flush_ex} actual=%b required=%b",
                   checks, act, exp);
        end
      end
    end
  end

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    vec_vld = 1'b0;
    reset   = 1'b1;

    // Outputs are combinational and must follow inputs even during reset.
    apply(NoHazard,      0, PcPlus4,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    apply(HazardExecute, 1, PcPlus4,  1, 9, 9, 0, 1, 0, 1, 0, 0, 0, 4'b1101);
    reset = 1'b0;
    apply(HazardDecode,  0, PcPlus4,  5, 0, 5, 0, 1, 0, 0, 0, 0, 0, 4'b1101);
    apply(HazardDecode,  0, PcPlus4,  5, 0, 5, 0, 1, 0, 0, 0, 0, 1, 4'b0000);
    apply(HazardDecode,  1, PcPlus4,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0000);
    apply(HazardDecode,  0, PcPlus4,  3, 7, 0, 7, 0, 1, 0, 1, 0, 0, 4'b0000);
    apply(HazardDecode,  1, PcPlus4,  3, 7, 0, 7, 0, 1, 0, 1, 0, 0, 4'b1101);
    apply(HazardDecode,  0, PcPlus4,  4, 0, 0, 4, 0, 1, 0, 1, 0, 0, 4'b1101);
    apply(HazardDecode,  0, PcPlus4,  4, 0, 0, 4, 0, 1, 0, 0, 0, 0, 4'b0000);
    apply(HazardDecode,  0, PcPlus4,  5, 0, 5, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    apply(HazardExecute, 1, PcPlus4,  1, 9, 9, 0, 1, 0, 1, 0, 0, 0, 4'b1101);
    apply(HazardExecute, 1, PcPlus4,  1, 9, 9, 0, 1, 0, 1, 0, 1, 0, 4'b0000);
    apply(HazardExecute, 1, PcPlus4,  9, 9, 9, 0, 1, 0, 1, 0, 1, 0, 4'b1101);
    apply(HazardExecute, 1, PcPlus4,  1, 9, 9, 0, 1, 0, 0, 0, 0, 0, 4'b0000);
    apply(HazardException, 1, PcPlus4, 5, 5, 5, 5, 1, 1, 1, 1, 0, 0, 4'b0011);
    apply(NoHazard,      0, PcBranch, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010);
    apply(NoHazard,      1, PcJalr,   5, 5, 5, 5, 1, 1, 1, 1, 0, 0, 4'b0010);
    apply(HazardDecode,  0, PcJal,    5, 0, 5, 0, 1, 0, 0, 0, 0, 0, 4'b1111);
    apply(HazardException, 0, PcJal,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011);

    for (int i = 0; i < 2000; i++) begin
      hazard_t    ht;
      pc_src_t    pc;
      logic       ru, wee, wem, mre, mrm, st, cmp;
      logic [4:0] rs1, rs2, rde, rdm;
      ht  = hazard_t'($urandom_range(0, 3));
      pc  = ($urandom_range(0, 3) == 0) ? pc_src_t'($urandom_range(1, 3)) : PcPlus4;
      ru  = 1'($urandom_range(0, 1));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rde = 5'($urandom_range(0, 3));
      rdm = 5'($urandom_range(0, 3));
      wee = 1'($urandom_range(0, 1));
      wem = 1'($urandom_range(0, 1));
      mre = 1'($urandom_range(0, 1));
      mrm = 1'($urandom_range(0, 1));
      st  = 1'($urandom_range(0, 1));
      cmp = 1'($urandom_range(0, 1));
      apply(ht, ru, pc, rs1, rs2, rde, rdm, wee, wem, mre, mrm, st, cmp,
            model(ht, ru, pc, rs1, rs2, rde, rdm, wee, wem, mre, mrm, st, cmp));
    end

`ifdef HAZARD_STATS_EN
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    vec_vld = 1'b0;
    repeat (3) apply(HazardDecode, 0, PcPlus4, 5, 0, 5, 0, 1, 0, 0, 0, 0, 0, 4'b1101);
    apply(NoHazard, 0, PcPlus4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    @(negedge clock);
    check32("stall_count_after_3", hif.stall_count, 32'd3);
    check32("flush_count_after_3", hif.flush_count, 32'd3);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check32("stall_count_reset", hif.stall_count, 32'd0);
    check32("flush_count_reset", hif.flush_count, 32'd0);
    force dut.u_stall_cnt.r_count = 32'hFFFF_FFFF;
    #1;
    release dut.u_stall_cnt.r_count;
    apply(HazardDecode, 0, PcPlus4, 5, 0, 5, 0, 1, 0, 0, 0, 0, 0, 4'b1101);
    apply(NoHazard, 0, PcPlus4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    @(negedge clock);
    check32("stall_count_wrap", hif.stall_count, 32'd0);
`endif

    @(posedge clock);
    #1;
    vec_vld = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clock);
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
